// File: rtl/usb_txn_sequencer.sv
// rtl/usb_txn_sequencer.sv - USB host READ/WRITE transaction sequencer with NAK/timeout retry.
// Optional NAK/timeout statistics counters are built when USB_TXN_STATS_EN is defined.
module usb_txn_sequencer #(
  parameter logic [6:0]  DEV_ADDR  = 7'd5,
  parameter logic [3:0]  ENDP_PAGE = 4'd4,
  parameter logic [3:0]  ENDP_DATA = 4'd8,
  parameter int unsigned MAX_RETRY = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_read,
  input  logic [15:0] mempage,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        success,
  output logic [63:0] rdata,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [3:0]  tx_pid,
  output logic [6:0]  tx_addr,
  output logic [3:0]  tx_endp,
  output logic [63:0] tx_data,
  output logic [3:0]  tx_bytes,
  input  logic        rx_valid,
  input  logic [3:0]  rx_pid,
  input  logic [63:0] rx_data,
  input  logic        rx_crc_ok,
  output logic [7:0]  nak_cnt,
  output logic [7:0]  tmo_cnt
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, P1_TOK, P1_DAT, P1_HS, P2_TOK, P2_DAT, P2_HS, P2_RX, SEND_HS, FIN
  } state_t;

  state_t      state_q, state_d;
  logic        is_read_q, is_read_d;
  logic [15:0] mempage_q, mempage_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        success_q, success_d;
  logic        hs_ack_q, hs_ack_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  timer_q, timer_d;

  logic        in_wait, timeout, do_retry;
  logic [3:0]  retry_inc;
  state_t      retry_tgt;

  assign in_wait   = state_q inside {P1_HS, P2_HS, P2_RX};
  assign timeout   = in_wait && (timer_q == TMO_LAST) && !rx_valid;
  assign retry_inc = retry_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    is_read_d = is_read_q;
    mempage_d = mempage_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    success_d = success_q;
    hs_ack_d  = hs_ack_q;
    retry_d   = retry_q;
    timer_d   = in_wait ? timer_q + 8'd1 : 8'd0;
    do_retry  = 1'b0;
    retry_tgt = P1_TOK;
    tx_valid  = 1'b0;
    tx_pid    = 4'd0;
    tx_addr   = 7'd0;
    tx_endp   = 4'd0;
    tx_data   = 64'd0;
    tx_bytes  = 4'd0;

    unique case (state_q)
      IDLE: if (start) begin
        is_read_d = is_read;
        mempage_d = mempage;
        wdata_d   = wdata;
        retry_d   = 4'd0;
        success_d = 1'b0;
        state_d   = P1_TOK;
      end
      P1_TOK: begin
        tx_valid = 1'b1;
        tx_pid   = PID_OUT;
        tx_addr  = DEV_ADDR;
        tx_endp  = ENDP_PAGE;
        if (tx_ready) state_d = P1_DAT;
      end
      P1_DAT: begin
        tx_valid = 1'b1;
        tx_pid   = PID_DATA0;
        tx_data  = {48'd0, mempage_q};
        tx_bytes = 4'd2;
        if (tx_ready) state_d = P1_HS;
      end
      P1_HS: begin
        retry_tgt = P1_TOK;
        if (rx_valid) begin
          if (rx_pid == PID_ACK) begin
            retry_d = 4'd0;
            state_d = P2_TOK;
          end else begin
            do_retry = 1'b1;
          end
        end else if (timeout) begin
          do_retry = 1'b1;
        end
      end
      P2_TOK: begin
        tx_valid = 1'b1;
        tx_pid   = is_read_q ? PID_IN : PID_OUT;
        tx_addr  = DEV_ADDR;
        tx_endp  = ENDP_DATA;
        if (tx_ready) state_d = is_read_q ? P2_RX : P2_DAT;
      end
      P2_DAT: begin
        tx_valid = 1'b1;
        tx_pid   = PID_DATA0;
        tx_data  = wdata_q;
        tx_bytes = 4'd8;
        if (tx_ready) state_d = P2_HS;
      end
      P2_HS: begin
        retry_tgt = P2_TOK;
        if (rx_valid) begin
          if (rx_pid == PID_ACK) begin
            success_d = 1'b1;
            state_d   = FIN;
          end else begin
            do_retry = 1'b1;
          end
        end else if (timeout) begin
          do_retry = 1'b1;
        end
      end
      P2_RX: begin
        retry_tgt = P2_TOK;
        // Unexpected PIDs here are dropped; the timer keeps running.
        if (rx_valid) begin
          if (rx_pid == PID_DATA0) begin
            hs_ack_d = rx_crc_ok;
            if (rx_crc_ok) rdata_d = rx_data;
            state_d  = SEND_HS;
          end else if (rx_pid == PID_NAK) begin
            do_retry = 1'b1;
          end
        end else if (timeout) begin
          hs_ack_d = 1'b0;
          state_d  = SEND_HS;
        end
      end
      SEND_HS: begin
        retry_tgt = P2_TOK;
        tx_valid  = 1'b1;
        tx_pid    = hs_ack_q ? PID_ACK : PID_NAK;
        if (tx_ready) begin
          if (hs_ack_q) begin
            success_d = 1'b1;
            state_d   = FIN;
          end else begin
            do_retry = 1'b1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (do_retry) begin
      retry_d = retry_inc;
      if (retry_inc == RETRY_LIM) begin
        success_d = 1'b0;
        state_d   = FIN;
      end else begin
        state_d = retry_tgt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      is_read_q <= 1'b0;
      mempage_q <= 16'd0;
      wdata_q   <= 64'd0;
      rdata_q   <= 64'd0;
      success_q <= 1'b0;
      hs_ack_q  <= 1'b0;
      retry_q   <= 4'd0;
      timer_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      is_read_q <= is_read_d;
      mempage_q <= mempage_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      success_q <= success_d;
      hs_ack_q  <= hs_ack_d;
      retry_q   <= retry_d;
      timer_q   <= timer_d;
    end
  end

  assign busy    = (state_q != IDLE) && (state_q != FIN);
  assign done    = (state_q == FIN);
  assign success = success_q;
  assign rdata   = rdata_q;

`ifdef USB_TXN_STATS_EN
  logic [7:0] nak_cnt_q, nak_cnt_d, tmo_cnt_q, tmo_cnt_d;
  logic       nak_seen;

  assign nak_seen = in_wait && rx_valid && (rx_pid == PID_NAK);

  always_comb begin
    nak_cnt_d = nak_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    if (nak_seen && nak_cnt_q != 8'hFF) nak_cnt_d = nak_cnt_q + 8'd1;
    if (timeout && tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      nak_cnt_q <= 8'd0;
      tmo_cnt_q <= 8'd0;
    end else begin
      nak_cnt_q <= nak_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign nak_cnt = nak_cnt_q;
  assign tmo_cnt = tmo_cnt_q;
`else
  assign nak_cnt = 8'd0;
  assign tmo_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_usb_txn_sequencer.sv
// tb/tb_usb_txn_sequencer.sv - directed self-checking bench for usb_txn_sequencer.
module tb_usb_txn_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, is_read = 1'b0;
  logic [15:0] mempage = 16'd0;
  logic [63:0] wdata = 64'd0;
  logic        busy, done, success;
  logic [63:0] rdata;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [3:0]  tx_pid;
  logic [6:0]  tx_addr;
  logic [3:0]  tx_endp;
  logic [63:0] tx_data;
  logic [3:0]  tx_bytes;
  logic        rx_valid = 1'b0;
  logic [3:0]  rx_pid = 4'd0;
  logic [63:0] rx_data = 64'd0;
  logic        rx_crc_ok = 1'b0;
  logic [7:0]  nak_cnt, tmo_cnt;

  usb_txn_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .is_read(is_read),
    .mempage(mempage), .wdata(wdata), .busy(busy), .done(done),
    .success(success), .rdata(rdata), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_pid(tx_pid), .tx_addr(tx_addr), .tx_endp(tx_endp), .tx_data(tx_data),
    .tx_bytes(tx_bytes), .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_data(rx_data),
    .rx_crc_ok(rx_crc_ok), .nak_cnt(nak_cnt), .tmo_cnt(tmo_cnt)
  );

  always #5 clock = ~clock;

`ifdef USB_TXN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [3:0] OUT = 4'b0001, IN = 4'b1001, DATA0 = 4'b0011;
  localparam logic [3:0] ACK = 4'b0010, NAK = 4'b1010;

  typedef logic [82:0] pkt_t;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] rd_saved = 64'd0;

  function automatic pkt_t mk(logic [3:0] pid, logic [6:0] a, logic [3:0] e,
                              logic [3:0] b, logic [63:0] d);
    return {pid, a, e, b, d};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for a packet request and lets it transfer; all-X if none appears.
  task automatic get_tx(output pkt_t p);
    p = 'x;
    for (int i = 0; i < 400; i++) begin
      if (tx_valid) begin
        p = {tx_pid, tx_addr, tx_endp, tx_bytes, tx_data};
        tick();
        return;
      end
      tick();
    end
  endtask

  task automatic send_rx(input logic [3:0] pid, input logic [63:0] d, input logic crc);
    rx_valid = 1'b1; rx_pid = pid; rx_data = d; rx_crc_ok = crc;
    tick();
    rx_valid = 1'b0; rx_pid = 4'd0; rx_data = 64'd0; rx_crc_ok = 1'b0;
  endtask

  task automatic kick(input logic rd, input logic [15:0] pg, input logic [63:0] wd);
    start = 1'b1; is_read = rd; mempage = pg; wdata = wd;
    tick();
    start = 1'b0; is_read = 1'b0; mempage = 16'd0; wdata = 64'd0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin seen = 1'b1; return; end
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    vectors++; if ({busy, done, success, tx_valid} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got %b want 0000", {busy, done, success, tx_valid}); end
    vectors++; if (rdata !== 64'd0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", rdata); end
    vectors++; if ({nak_cnt, tmo_cnt} !== 16'd0) begin miscompares++; $display("FAIL reset_stats got %h want 0", {nak_cnt, tmo_cnt}); end
  endtask

  task automatic test_write;
    pkt_t p, e;
    bit seen;
    kick(1'b0, 16'h0042, 64'hDEAD_BEEF_0123_4567);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wr_busy got %b want 1", busy); end
    get_tx(p); e = mk(OUT, 7'd5, 4'd4, 4'd0, 64'd0);
    vectors++; if (p !== e) begin miscompares++; $display("FAIL wr_p1_tok got %h want %h", p, e); end
    get_tx(p); e = mk(DATA0, 7'd0, 4'd0, 4'd2, 64'h42);
    vectors++; if (p !== e) begin miscompares++; $display("FAIL wr_p1_dat got %h want %h", p, e); end
    start = 1'b1; is_read = 1'b1;
    tick();
    start = 1'b0; is_read = 1'b0;
    send_rx(ACK, 64'd0, 1'b0);
    get_tx(p); e = mk(OUT, 7'd5, 4'd8, 4'd0, 64'd0);
    vectors++; if (p !== e) begin miscompares++; $display("FAIL wr_p2_tok got %h want %h", p, e); end
    get_tx(p); e = mk(DATA0, 7'd0, 4'd0, 4'd8, 64'hDEAD_BEEF_0123_4567);
    vectors++; if (p !== e) begin miscompares++; $display("FAIL wr_p2_dat got %h want %h", p, e); end
    send_rx(ACK, 64'd0, 1'b0);
    wait_done(seen);
    vectors++; if ({seen, success, busy} !== 3'b110) begin miscompares++; $display("FAIL wr_done got seen/success/busy=%b want 110", {seen, success, busy}); end
    vectors++; if (rdata !== 64'd0) begin miscompares++; $display("FAIL wr_rdata got %h want 0", rdata); end
    tick();
    vectors++; if ({done, busy} !== 2'b00) begin miscompares++; $display("FAIL wr_done_pulse got done/busy=%b want 00", {done, busy}); end
  endtask

  task automatic test_read;
    pkt_t p, e;
    bit seen;
    kick(1'b1, 16'h0007, 64'd0);
    get_tx(p); e = mk(OUT, 7'd5, 4'd4, 4'd0, 64'd0);
    vectors++; if (p !== e) begin miscompares++; $display("FAIL rd_p1_tok got %h want %h", p, e); end
    get_tx(p); e = mk(DATA0, 7'd0, 4'd0, 4'd2, 64'h7);
    vectors++; if (p !== e) begin miscompares++; $display("FAIL rd_p1_dat got %h want %h", p, e); end
    send_rx(ACK, 64'd0, 1'b0);
    get_tx(p); e = mk(IN, 7'd5, 4'd8, 4'd0, 64'd0);
    vectors++; if (p !== e) begin miscompares++; $display("FAIL rd_in got %h want %h", p, e); end
    send_rx(DATA0, 64'h1122_3344_5566_7788, 1'b1);
    get_tx(p); e = mk(ACK, 7'd0, 4'd0, 4'd0, 64'd0);
    vectors++; if (p !== e) begin miscompares++; $display("FAIL rd_ack got %h want %h", p, e); end
    wait_done(seen);
    vectors++; if ({seen, success} !== 2'b11) begin miscompares++; $display("FAIL rd_done got seen/success=%b want 11", {seen, success}); end
    vectors++; if (rdata !== 64'h1122_3344_5566_7788) begin miscompares++; $display("FAIL rd_rdata got %h want 1122334455667788", rdata); end
    tick();
  endtask

  task automatic test_read_crc_retry;
    pkt_t p, e;
    bit seen;
    kick(1'b1, 16'h0100, 64'd0);
    get_tx(p);
    get_tx(p);
    send_rx(ACK, 64'd0, 1'b0);
    get_tx(p);
    send_rx(DATA0, 64'hFFFF_0000_FFFF_0000, 1'b0);
    get_tx(p); e = mk(NAK, 7'd0, 4'd0, 4'd0, 64'd0);
    vectors++; if (p !== e) begin miscompares++; $display("FAIL crc_nak got %h want %h", p, e); end
    get_tx(p); e = mk(IN, 7'd5, 4'd8, 4'd0, 64'd0);
    vectors++; if (p !== e) begin miscompares++; $display("FAIL crc_in_again got %h want %h", p, e); end
    send_rx(DATA0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
    get_tx(p); e = mk(ACK, 7'd0, 4'd0, 4'd0, 64'd0);
    vectors++; if (p !== e) begin miscompares++; $display("FAIL crc_ack got %h want %h", p, e); end
    wait_done(seen);
    vectors++; if ({seen, success} !== 2'b11) begin miscompares++; $display("FAIL crc_done got seen/success=%b want 11", {seen, success}); end
    vectors++; if (rdata !== 64'hA5A5_5A5A_0F0F_F0F0) begin miscompares++; $display("FAIL crc_rdata got %h want a5a55a5a0f0ff0f0", rdata); end
    vectors++; if ({nak_cnt, tmo_cnt} !== 16'd0) begin miscompares++; $display("FAIL crc_stats got %h want 0", {nak_cnt, tmo_cnt}); end
    rd_saved = 64'hA5A5_5A5A_0F0F_F0F0;
    tick();
  endtask

  task automatic test_nak_limit;
    pkt_t p, e;
    bit seen;
    kick(1'b0, 16'h0003, 64'h0102_0304_0506_0708);
    get_tx(p);
    get_tx(p);
    send_rx(ACK, 64'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      get_tx(p); e = mk(OUT, 7'd5, 4'd8, 4'd0, 64'd0);
      vectors++; if (p !== e) begin miscompares++; $display("FAIL nak_tok%0d got %h want %h", i, p, e); end
      get_tx(p); e = mk(DATA0, 7'd0, 4'd0, 4'd8, 64'h0102_0304_0506_0708);
      vectors++; if (p !== e) begin miscompares++; $display("FAIL nak_dat%0d got %h want %h", i, p, e); end
      send_rx(NAK, 64'd0, 1'b0);
    end
    wait_done(seen);
    vectors++; if ({seen, success, tx_valid} !== 3'b100) begin miscompares++; $display("FAIL nak_done got seen/success/tx_valid=%b want 100", {seen, success, tx_valid}); end
    vectors++; if (nak_cnt !== (STATS ? 8'd8 : 8'd0)) begin miscompares++; $display("FAIL nak_cnt got %0d want %0d", nak_cnt, STATS ? 8 : 0); end
    vectors++; if (rdata !== rd_saved) begin miscompares++; $display("FAIL nak_rdata_hold got %h want %h", rdata, rd_saved); end
    tick();
  endtask

  task automatic test_timeout_stall;
    pkt_t p, e, held;
    bit seen;
    int n;
    kick(1'b0, 16'h1234, 64'h0BAD_F00D_CAFE_0001);
    get_tx(p);
    tx_ready = 1'b0;
    held = {tx_pid, tx_addr, tx_endp, tx_bytes, tx_data};
    e = mk(DATA0, 7'd0, 4'd0, 4'd2, 64'h1234);
    vectors++; if ({tx_valid, held} !== {1'b1, e}) begin miscompares++; $display("FAIL tmo_stall_start got %h want %h", held, e); end
    for (int k = 0; k < 3; k++) begin
      tick();
      p = {tx_pid, tx_addr, tx_endp, tx_bytes, tx_data};
      vectors++; if ({tx_valid, p} !== {1'b1, e}) begin miscompares++; $display("FAIL tmo_stall%0d got %h want %h", k, p, e); end
    end
    tx_ready = 1'b1;
    tick();
    n = 0;
    while (!tx_valid && n < 300) begin tick(); n++; end
    vectors++; if (n !== 255) begin miscompares++; $display("FAIL tmo_cycles got %0d want 255", n); end
    get_tx(p); e = mk(OUT, 7'd5, 4'd4, 4'd0, 64'd0);
    vectors++; if (p !== e) begin miscompares++; $display("FAIL tmo_resend got %h want %h", p, e); end
    vectors++; if (tmo_cnt !== (STATS ? 8'd1 : 8'd0)) begin miscompares++; $display("FAIL tmo_cnt got %0d want %0d", tmo_cnt, STATS ? 1 : 0); end
    get_tx(p);
    repeat (254) tick();
    send_rx(ACK, 64'd0, 1'b0);
    get_tx(p); e = mk(OUT, 7'd5, 4'd8, 4'd0, 64'd0);
    vectors++; if (p !== e) begin miscompares++; $display("FAIL tmo_rx_priority got %h want %h", p, e); end
    vectors++; if (tmo_cnt !== (STATS ? 8'd1 : 8'd0)) begin miscompares++; $display("FAIL tmo_cnt_hold got %0d want %0d", tmo_cnt, STATS ? 1 : 0); end
    get_tx(p);
    send_rx(ACK, 64'd0, 1'b0);
    wait_done(seen);
    vectors++; if ({seen, success} !== 2'b11) begin miscompares++; $display("FAIL tmo_done got seen/success=%b want 11", {seen, success}); end
    tick();
  endtask

  task automatic test_reset_mid;
    pkt_t p, e;
    kick(1'b1, 16'h0055, 64'd0);
    get_tx(p);
    get_tx(p);
    send_rx(ACK, 64'd0, 1'b0);
    get_tx(p);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_mid_busy_before got %b want 1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++; if ({busy, done, tx_valid} !== 3'b000) begin miscompares++; $display("FAIL rst_mid_abort got busy/done/tx_valid=%b want 000", {busy, done, tx_valid}); end
    vectors++; if ({rdata, nak_cnt, tmo_cnt} !== 80'd0) begin miscompares++; $display("FAIL rst_mid_clear got %h want 0", {rdata, nak_cnt, tmo_cnt}); end
    kick(1'b0, 16'h0001, 64'd9);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_mid_restart got %b want 1", busy); end
    get_tx(p); e = mk(OUT, 7'd5, 4'd4, 4'd0, 64'd0);
    vectors++; if (p !== e) begin miscompares++; $display("FAIL rst_mid_tok got %h want %h", p, e); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_crc_retry();
    test_nak_limit();
    test_timeout_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usb_txn_sequencer.md
Name: usb_txn_sequencer

Overview:
- Sequences one USB host READ or WRITE transaction per request.
- Phase 1 sends the memory page: OUT token, then DATA0 carrying mempage.
- Phase 2 moves data: WRITE sends OUT + DATA0(wdata); READ sends IN, then receives DATA0.
- Sits between host-level request logic and the packet encoder/decoder driving USBWires. Owns the NAK/timeout retry policy and the handshake replies.

Parameters:
- DEV_ADDR, 5, 7-bit device address placed in every token.
- ENDP_PAGE, 4, endpoint for the mempage (phase 1).
- ENDP_DATA, 8, endpoint for the data (phase 2).
- MAX_RETRY, 8, per-phase retries before the transaction fails.
- TIMEOUT, 255, idle cycles waited for a response packet.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  1-cycle request pulse; ignored unless idle
- is_read  in  1  1 = READ, 0 = WRITE; sampled with start
- mempage  in  16  page number; sampled with start
- wdata  in  64  write payload; sampled with start
- busy  out  1  transaction in progress
- done  out  1  1-cycle completion pulse
- success  out  1  result; valid when done=1
- rdata  out  64  read payload; valid when done=1 && success=1 && READ
- tx_valid  out  1  packet request to encoder
- tx_ready  in  1  encoder accepts packet
- tx_pid  out  4  PID: OUT=0001, IN=1001, DATA0=0011, ACK=0010, NAK=1010
- tx_addr  out  7  token address
- tx_endp  out  4  token endpoint
- tx_data  out  64  DATA payload, LSB first
- tx_bytes  out  4  payload length: 2 for mempage, 8 for data, 0 otherwise
- rx_valid  in  1  decoder delivered a packet this cycle
- rx_pid  in  4  received PID
- rx_data  in  64  received payload
- rx_crc_ok  in  1  CRC16 check passed; qualifies DATA packets
- nak_cnt  out  8  saturating NAK counter (optional feature)
- tmo_cnt  out  8  saturating timeout counter (optional feature)

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - busy, done, success, tx_valid = 0; rdata = 0; retry and timer counters = 0.
  - Reset mid-transaction aborts it immediately. No done pulse.
- States: IDLE, P1_TOK, P1_DAT, P1_HS, P2_TOK, P2_DAT, P2_HS, P2_RX, SEND_HS, FIN.
- Transmit handshake:
  - tx_* stay stable while tx_valid=1 && tx_ready=0.
  - A transfer occurs on the cycle tx_valid && tx_ready; the FSM advances on that cycle.
- Start:
  - IDLE + start latches the inputs, sets busy the next cycle, and enters P1_TOK.
  - start while busy is ignored.
- P1_TOK sends OUT(DEV_ADDR, ENDP_PAGE) -> P1_DAT.
- P1_DAT sends DATA0 (tx_data[15:0]=mempage, upper bits 0, tx_bytes=2) -> P1_HS.
- P1_HS waits for a response:
  - rx ACK -> P2_TOK; retry count cleared.
  - rx NAK, or TIMEOUT cycles with no rx_valid -> retry, back to P1_TOK.
  - Any other PID is treated as NAK.
- P2_TOK:
  - WRITE sends OUT(DEV_ADDR, ENDP_DATA) -> P2_DAT.
  - READ sends IN(DEV_ADDR, ENDP_DATA) -> P2_RX.
- P2_DAT sends DATA0 (wdata, tx_bytes=8) -> P2_HS.
- P2_HS: same ACK/NAK/timeout rules as P1_HS. ACK -> FIN with success=1; retry -> P2_TOK.
- P2_RX:
  - rx DATA0 with rx_crc_ok=1: capture rx_data, queue ACK -> SEND_HS, then FIN with success=1.
  - rx DATA0 with rx_crc_ok=0, or timeout: queue NAK -> SEND_HS, then retry at P2_TOK.
  - rx NAK from the device: retry at P2_TOK; no handshake is sent.
- Retry:
  - Increment the phase retry count.
  - If the count reaches MAX_RETRY, go to FIN with success=0 instead of retrying.
  - A pending handshake transmit is still completed first.
- Timeout timer:
  - Cleared on entry to P1_HS, P2_HS and P2_RX; counts only in those states.
  - Fires when it equals TIMEOUT-1 with no rx_valid.
  - rx_valid on the same cycle as expiry takes priority over the timeout.
- rx_valid outside a wait state is ignored.
- FIN: done=1 for one cycle, success held, busy drops the same cycle, next state IDLE.
  - A start in the FIN cycle is ignored.
  - rdata holds until the next successful READ.

Optional Feature:
- Macro USB_TXN_STATS_EN.
- Defined:
  - nak_cnt increments on each received NAK.
  - tmo_cnt increments on each timeout.
  - Both saturate at 255, clear only on reset, and are not cleared per transaction.
- Undefined: nak_cnt and tmo_cnt are tied to 0 and no counter flops exist.
- FSM behaviour is identical either way.

Test Plan:
- WRITE, mempage=16'h0042, wdata=64'hDEAD_BEEF_0123_4567, device ACKs both phases with tx_ready always 1 -> tx sequence OUT(5,4), DATA0(0042, 2B), OUT(5,8), DATA0(data, 8B); done=1 with success=1.
- READ, mempage=16'h0007, device ACKs phase 1 and returns DATA0 64'h1122_3344_5566_7788 with CRC ok -> IN(5,8), then host sends ACK; done=1, success=1, rdata=64'h1122334455667788.
- READ where the first DATA0 has rx_crc_ok=0 and the second is good -> host sends NAK, then re-sends IN(5,8), then sends ACK; success=1; tmo_cnt=0.
- WRITE where the device NAKs phase 2 eight times -> eight OUT/DATA0 pairs in phase 2; done=1 with success=0; nak_cnt=8 with STATS_EN defined.
- No response to phase 1 DATA0 -> timeout after 255 cycles, phase 1 resent; tmo_cnt increments; tx_ready held low 3 cycles mid-packet -> tx_* stable across those cycles.
- reset asserted during P2_RX -> the next cycle busy=0 with no done pulse; a new start is accepted immediately.
